clock_divider_bank: RTL

Parametrised bank of independent programmable clock dividers, all in the single `clock` domain. Each channel produces a divided square wave plus single-cycle rise/fall strobes for downstream clock-enable use, such as Atlas-bus MCLK and SPI bit clocks. Divisor changes take effect only at period boundaries, so no runt pulses occur. A common `sync` input phase-aligns all enabled channels.

---
 rtl/clocks_pkg.sv | 17 +
 rtl/clock_divider_channel.sv | 65 ++++++
 rtl/clock_divider_bank.sv | 33 +++
 3 files changed

// File: rtl/clocks_pkg.sv
// Shared constants and helpers for the clock divider bank.
package clocks_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned DIV_MIN       = 2;

  // Divisors below DIV_MIN cannot form a square wave; clamp them.
  function automatic int unsigned div_sat(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  // High phase length: ceil(d/2).
  function automatic int unsigned high_cycles(input int unsigned d);
    return d - (d >> 1);
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: period counter, latched divisor, divided clock and
// single-cycle rise/fall strobes. Divisor is only picked up at a restart.
module clock_divider_channel
  import clocks_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] divisor,
  input  logic             enable,
  input  logic             sync,
  output logic             clk_out,
  output logic             rise_stb,
  output logic             fall_stb
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] d_act;
  logic             run;

  logic [CNT_W-1:0] cnt_inc;
  logic             stay_high;
  logic             at_wrap;
  logic             restart;

  // Next-count value, high-phase test and restart decision.
  always_comb begin
    cnt_inc   = cnt + CNT_W'(1);
    stay_high = 32'(cnt_inc) < high_cycles(32'(d_act));
    at_wrap   = (cnt == d_act - CNT_W'(1));
    restart   = sync || !run || at_wrap;
  end

  // Channel state: disable has priority over restart, restart over count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      d_act    <= CNT_W'(DIV_MIN);
      run      <= 1'b0;
      clk_out  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else if (!enable) begin
      cnt      <= '0;
      run      <= 1'b0;
      clk_out  <= 1'b0;
      rise_stb <= 1'b0;
      fall_stb <= clk_out;
    end else if (restart) begin
      cnt      <= '0;
      run      <= 1'b1;
      d_act    <= CNT_W'(div_sat(32'(divisor)));
      clk_out  <= 1'b1;
      rise_stb <= ~clk_out;
      fall_stb <= 1'b0;
    end else begin
      cnt      <= cnt_inc;
      clk_out  <= stay_high;
      rise_stb <= 1'b0;
      fall_stb <= clk_out & ~stay_high;
    end
  end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent programmable clock dividers sharing one sync input.
module clock_divider_bank
  import clocks_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*CNT_W-1:0] divisor,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       rise_stb,
  output logic [CHANNELS-1:0]       fall_stb
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    clock_divider_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clock    (clock),
      .reset    (reset),
      .divisor  (divisor[g*CNT_W +: CNT_W]),
      .enable   (enable[g]),
      .sync     (sync),
      .clk_out  (clk_out[g]),
      .rise_stb (rise_stb[g]),
      .fall_stb (fall_stb[g])
    );
  end

endmodule
